// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS datapath: hazard FSM encoding,
// architectural constants and the default mult/div latency.
package mips_pkg;

    typedef enum logic {
        HZ_RUN     = 1'b0,
        HZ_MD_WAIT = 1'b1
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int unsigned MD_CYCLES_DEFAULT = 32;

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and mult/div stalls, taken-branch
// squash, and a free-running stall-cycle counter.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MD_CYCLES = MD_CYCLES_DEFAULT,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idexMemRead,
    input  logic [4:0]       idexRt,
    input  logic             idexMulDiv,
    input  logic [4:0]       ifidRs,
    input  logic [4:0]       ifidRt,
    input  logic             ifidUsesRt,
    input  logic             ifidHiLo,
    input  logic             branchTaken,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             idexBubble,
    output logic             mdBusy,
    output logic [CNT_W-1:0] stallCount
);

    localparam int unsigned MD_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_CYCLES - 2);

    hz_state_t       state;
    logic [MD_W-1:0] mdCnt;
    logic            lu;
    logic            md;
    logic            stall;

    function automatic logic load_use_hit(
        input logic       memRead,
        input logic [4:0] exRt,
        input logic [4:0] idRs,
        input logic [4:0] idRt,
        input logic       usesRt
    );
        return memRead && (exRt != REG_ZERO) &&
               ((exRt == idRs) || (usesRt && (exRt == idRt)));
    endfunction

    always_comb begin
        lu    = load_use_hit(idexMemRead, idexRt, ifidRs, ifidRt, ifidUsesRt);
        md    = (state == HZ_MD_WAIT) && ifidHiLo;
        stall = (lu || md) && !branchTaken;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HZ_RUN;
            mdCnt      <= '0;
            stallCount <= '0;
        end else begin
            if (stall)
                stallCount <= stallCount + 1'b1;

            // A mult/div already in EX runs to completion; branches do not abort it.
            unique case (state)
                HZ_RUN: begin
                    if (idexMulDiv) begin
                        state <= HZ_MD_WAIT;
                        mdCnt <= MD_LOAD;
                    end
                end
                HZ_MD_WAIT: begin
                    if (mdCnt == '0)
                        state <= HZ_RUN;
                    else
                        mdCnt <= mdCnt - 1'b1;
                end
                default: begin
                    state <= HZ_RUN;
                    mdCnt <= '0;
                end
            endcase
        end
    end

    // Reset forces the pipeline to free-run, even if the FSM was mid-wait.
    always_comb begin
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        ifidFlush  = 1'b0;
        idexBubble = 1'b0;
        mdBusy     = 1'b0;
        if (!reset) begin
            mdBusy = (state == HZ_MD_WAIT) || ((state == HZ_RUN) && idexMulDiv);
            if (branchTaken) begin
                ifidFlush  = 1'b1;
                idexBubble = 1'b1;
            end else if (stall) begin
                pcWrite    = 1'b0;
                ifidWrite  = 1'b0;
                idexBubble = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for single-cycle decode plus
// hand-written mult/div, reset-during-wait and counter-wrap sequences.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        idexMemRead;
    logic [4:0]  idexRt;
    logic        idexMulDiv;
    logic [4:0]  ifidRs;
    logic [4:0]  ifidRt;
    logic        ifidUsesRt;
    logic        ifidHiLo;
    logic        branchTaken;

    logic        pcWrite, ifidWrite, ifidFlush, idexBubble, mdBusy;
    logic [31:0] stallCount;
    logic        pcWrite2, ifidWrite2, ifidFlush2, idexBubble2, mdBusy2;
    logic [3:0]  stallCount2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_CYCLES(32), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .idexMemRead(idexMemRead), .idexRt(idexRt), .idexMulDiv(idexMulDiv),
        .ifidRs(ifidRs), .ifidRt(ifidRt), .ifidUsesRt(ifidUsesRt),
        .ifidHiLo(ifidHiLo), .branchTaken(branchTaken),
        .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
        .idexBubble(idexBubble), .mdBusy(mdBusy), .stallCount(stallCount)
    );

    hazard_ctrl #(.MD_CYCLES(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .idexMemRead(idexMemRead), .idexRt(idexRt), .idexMulDiv(idexMulDiv),
        .ifidRs(ifidRs), .ifidRt(ifidRt), .ifidUsesRt(ifidUsesRt),
        .ifidHiLo(ifidHiLo), .branchTaken(branchTaken),
        .pcWrite(pcWrite2), .ifidWrite(ifidWrite2), .ifidFlush(ifidFlush2),
        .idexBubble(idexBubble2), .mdBusy(mdBusy2), .stallCount(stallCount2)
    );

    typedef struct {
        logic       rst;
        logic       memRead;
        logic [4:0] exRt;
        logic       mulDiv;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic       hilo;
        logic       br;
        logic [4:0] exp;   // {pcWrite, ifidWrite, ifidFlush, idexBubble, mdBusy}
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic mr, input logic [4:0] er,
                         input logic mdv, input logic [4:0] rs, input logic [4:0] rt,
                         input logic ur, input logic hl, input logic br);
        reset = rst; idexMemRead = mr; idexRt = er; idexMulDiv = mdv;
        ifidRs = rs; ifidRt = rt; ifidUsesRt = ur; ifidHiLo = hl; branchTaken = br;
    endtask

    task automatic chk_outs(input string name, input logic [4:0] exp);
        chk(name, {27'd0, pcWrite, ifidWrite, ifidFlush, idexBubble, mdBusy}, {27'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
    endtask

    initial begin
        logic [31:0] model_cnt;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        //           rst mr  exRt md  rs  rt  ur hl br  exp
        vecs[0] = '{0, 1, 5'd3, 0, 5'd3, 5'd9, 0, 0, 0, 5'b00010};
        vecs[1] = '{0, 1, 5'd3, 0, 5'd8, 5'd3, 1, 0, 0, 5'b00010};
        vecs[2] = '{0, 1, 5'd3, 0, 5'd5, 5'd3, 0, 0, 0, 5'b11000};
        vecs[3] = '{0, 1, 5'd0, 0, 5'd0, 5'd0, 1, 0, 0, 5'b11000};
        vecs[4] = '{0, 0, 5'd3, 0, 5'd3, 5'd3, 1, 0, 0, 5'b11000};
        vecs[5] = '{0, 1, 5'd3, 0, 5'd3, 5'd0, 0, 0, 1, 5'b11110};
        vecs[6] = '{0, 0, 5'd0, 0, 5'd1, 5'd2, 1, 0, 1, 5'b11110};
        vecs[7] = '{0, 0, 5'd4, 0, 5'd4, 5'd4, 1, 1, 0, 5'b11000};
        vecs[8] = '{1, 1, 5'd7, 0, 5'd7, 5'd7, 1, 0, 0, 5'b11000};
        vecs[9] = '{0, 1, 5'd31, 0, 5'd30, 5'd31, 1, 0, 0, 5'b00010};

        do_reset();
        chk("reset_count", stallCount, 32'd0);
        chk_outs("reset_outs", 5'b11000);

        model_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rst, vecs[i].memRead, vecs[i].exRt, vecs[i].mulDiv,
                  vecs[i].rs, vecs[i].rt, vecs[i].usesRt, vecs[i].hilo, vecs[i].br);
            #1;
            chk($sformatf("vec%0d_outs", i), {27'd0, pcWrite, ifidWrite, ifidFlush,
                idexBubble, mdBusy}, {27'd0, vecs[i].exp});
            chk($sformatf("vec%0d_count", i), stallCount, model_cnt);
            if (vecs[i].rst)
                model_cnt = 0;
            else if (vecs[i].exp[1] && !vecs[i].exp[2])
                model_cnt = model_cnt + 1;
            tick();
        end
        chk("table_final_count", stallCount, model_cnt);

        // Single-cycle load-use stall followed by normal flow.
        do_reset();
        drive(0, 1, 5'd3, 0, 5'd3, 5'd0, 0, 0, 0);
        #1 chk_outs("lu_stall", 5'b00010);
        tick();
        drive(0, 0, 5'd0, 0, 5'd3, 5'd0, 0, 0, 0);
        #1 chk_outs("lu_release", 5'b11000);
        chk("lu_count", stallCount, 32'd1);
        tick();

        // Mult/div in EX at t, dependent instruction in ID from t+1.
        do_reset();
        drive(0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0, 0);
        #1 chk_outs("md_t", 5'b11001);
        tick();
        for (int c = 1; c <= 31; c++) begin
            drive(0, 0, 5'd0, 0, 5'd2, 5'd0, 0, 1, 0);
            #1 chk_outs($sformatf("md_t+%0d", c), 5'b00011);
            tick();
        end
        drive(0, 0, 5'd0, 0, 5'd2, 5'd0, 0, 1, 0);
        #1 chk_outs("md_t+32", 5'b11000);
        chk("md_count", stallCount, 32'd31);
        tick();

        // Branch during MD_WAIT squashes but does not end the wait.
        do_reset();
        drive(0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0, 0);
        tick();
        drive(0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 1, 1);
        #1 chk_outs("md_branch", 5'b11111);
        tick();
        drive(0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 1, 0);
        #1 chk_outs("md_after_branch", 5'b00011);
        chk("md_branch_count", stallCount, 32'd0);
        tick();

        // Reset asserted at t+10 of a mult/div wait.
        do_reset();
        drive(0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0, 0);
        tick();
        for (int c = 1; c < 10; c++) begin
            drive(0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 1, 0);
            tick();
        end
        chk("pre_reset_count", stallCount, 32'd9);
        drive(1, 0, 5'd0, 0, 5'd0, 5'd0, 0, 1, 0);
        #1 chk_outs("reset_mid_md", 5'b11000);
        tick();
        drive(0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 1, 0);
        #1 chk_outs("after_reset_md", 5'b11000);
        chk("after_reset_count", stallCount, 32'd0);
        tick();

        // 17 load-use stalls on the 4-bit counter instance.
        do_reset();
        for (int n = 0; n < 17; n++) begin
            drive(0, 1, 5'd6, 0, 5'd6, 5'd0, 0, 0, 0);
            tick();
            drive(0, 0, 5'd0, 0, 5'd6, 5'd0, 0, 0, 0);
            tick();
        end
        chk("wrap_cnt4", {28'd0, stallCount2}, 32'd1);
        chk("wrap_cnt32", stallCount, 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS datapath. It generates the PC write enable (`pcWrite`, wired to the PC register's `hzdWrite`), the IF/ID write and flush controls, and the ID/EX bubble insert. It detects load-use hazards, stalls on a multi-cycle multiply/divide unit, and squashes wrong-path instructions on a taken branch. A free-running stall counter supports performance measurement.

## Interface
- `MD_CYCLES`, default 32: mult/div latency in cycles, counted from the cycle the op is in EX; must be ≥ 2.
- `CNT_W`, default 32: width of the stall counter.

- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  reset, synchronous, active-high
- `idexMemRead`  in  1  the instruction in EX is a load
- `idexRt`  in  5  destination register of the instruction in EX
- `idexMulDiv`  in  1  the instruction in EX is mult/multu/div/divu
- `ifidRs`  in  5  rs field of the instruction in ID
- `ifidRt`  in  5  rt field of the instruction in ID
- `ifidUsesRt`  in  1  the instruction in ID reads rt as a source
- `ifidHiLo`  in  1  the instruction in ID is mfhi/mflo/mult/multu/div/divu
- `branchTaken`  in  1  a branch or jump resolved taken in EX this cycle
- `pcWrite`  out  1  PC load enable (to the PC register's `hzdWrite`)
- `ifidWrite`  out  1  IF/ID register load enable
- `ifidFlush`  out  1  clear IF/ID to a NOP
- `idexBubble`  out  1  zero the control bits entering ID/EX
- `mdBusy`  out  1  the mult/div unit is occupied
- `stallCount`  out  CNT_W  number of stall cycles since reset

## Operation
- States: `RUN` and `MD_WAIT`. A down-counter `mdCnt` (width clog2(MD_CYCLES)) is active only in `MD_WAIT`.
- Load-use hazard (`lu`): `idexMemRead` && `idexRt`≠0 && (`idexRt`==`ifidRs` || (`ifidUsesRt` && `idexRt`==`ifidRt`)).
- Mult/div hazard (`md`): state is `MD_WAIT` && `ifidHiLo`.
- Stall condition: `stall` = (`lu` || `md`) && !`branchTaken`.
- Outputs are combinational (Mealy) from the current state and inputs, evaluated in the same cycle:
  - `branchTaken`=1: `pcWrite`=1, `ifidWrite`=1, `ifidFlush`=1, `idexBubble`=1. Branch flush has priority over any stall.
  - `stall`=1: `pcWrite`=0, `ifidWrite`=0, `ifidFlush`=0, `idexBubble`=1.
  - Otherwise: `pcWrite`=1, `ifidWrite`=1, `ifidFlush`=0, `idexBubble`=0.
- FSM transitions:
  - `RUN`→`MD_WAIT` when `idexMulDiv`=1; load `mdCnt`=MD_CYCLES−2.
  - In `MD_WAIT`: if `mdCnt`==0, go to `RUN`; otherwise decrement `mdCnt`.
  - `branchTaken` does not abort `MD_WAIT`. An op already in EX always completes.
  - `idexMulDiv` cannot occur in `MD_WAIT`, because the `md` stall blocks it. If it is asserted there anyway, ignore it.
- `mdBusy` = (state==`MD_WAIT`) || (state==`RUN` && `idexMulDiv`).
- `stallCount` increments at posedge when `stall`=1. It wraps modulo 2^CNT_W and never saturates.

## Timing
- Reset (`reset`=1 at posedge): state→`RUN`, `mdCnt`→0, `stallCount`→0.
- While `reset` is high, outputs are forced to `pcWrite`=1, `ifidWrite`=1, `ifidFlush`=0, `idexBubble`=0, `mdBusy`=0. This holds even when reset is asserted mid-`MD_WAIT`.
- A load-use stall lasts exactly 1 cycle: the bubble moves into EX, so `idexMemRead` drops next cycle.
- A mult/div op is in EX in cycle t. `mdBusy` is high for cycles t .. t+MD_CYCLES−1. A dependent instruction in ID stalls through cycle t+MD_CYCLES−1 and advances at cycle t+MD_CYCLES.
- The PC register latches on negedge, so `pcWrite` must be stable by mid-cycle. All outputs depend only on posedge state and pipeline-register outputs.

## Structure
- Shared package `mips_pkg` holds:
  - the state encoding constants `HZ_RUN` and `HZ_MD_WAIT`,
  - the constant `REG_ZERO`=5'd0,
  - the default `MD_CYCLES`.
- No sub-module is needed. The hazard compare is a local function; the FSM and counters live in one always block. Output decode is in one combinational block.

## Test plan
- **Load-use on rs:** lw $3 in EX (`idexMemRead`=1, `idexRt`=3), `ifidRs`=3 → for 1 cycle `pcWrite`=0, `ifidWrite`=0, `idexBubble`=1; next cycle all normal; `stallCount`=1.
- **No hazard on $0:** `idexRt`=0 with `ifidRs`=0 → no stall. Also `ifidUsesRt`=0 with `idexRt`==`ifidRt` → no stall.
- **Mult/div stall:** `idexMulDiv` pulses at t, `ifidHiLo`=1 from t+1 → stall cycles t+1..t+31 (31 total); `pcWrite`=1 at t+32; `mdBusy` high t..t+31.
- **Branch over stall:** `branchTaken`=1 together with a load-use hit → `pcWrite`=1, `ifidFlush`=1, `idexBubble`=1; `stallCount` unchanged.
- **Reset mid-`MD_WAIT`:** assert `reset` at t+10 → next cycle state `RUN`, `mdBusy`=0, `stallCount`=0, `pcWrite`=1.
- **Counter wrap:** with CNT_W=4, run 17 load-use stalls → `stallCount`=1.
